// File: rtl/cla16_seq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package : cla_ctrl_pkg
// Brief   : Shared word width, sequencer state type and sizing helper.
// Revision: 1.0
// ============================================================================
package cla_ctrl_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } cla_seq_state_t;

  // Index width that never collapses to zero bits for a degenerate count of one.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla16_seq_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational one-hot pick of the first request at or after i_ptr.
// Revision: 1.0
// ============================================================================
module rr_arbiter
  import cla_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant
);

  logic [IDW-1:0] w_idx;

  // Walk from the farthest candidate back to the pointer so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_idx]) begin
        o_grant        = '0;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cla16_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cla16_seq_arbiter
// Brief   : Round-robin sequencer of multi-word additions on one shared 16-bit CLA.
// Revision: 1.0
// ============================================================================
module cla16_seq_arbiter
  import cla_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MAXW = 8,
  localparam int IDW = clog2_min1(NREQ),
  localparam int WIW = clog2_min1(MAXW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        i_req_valid,
  input  logic [NREQ*WORD_W-1:0] i_req_a,
  input  logic [NREQ*WORD_W-1:0] i_req_b,
  input  logic [NREQ-1:0]        i_req_cin,
  input  logic [NREQ-1:0]        i_req_last,
  output logic [NREQ-1:0]        o_req_ready,
  output logic [WORD_W-1:0]      o_add_a,
  output logic [WORD_W-1:0]      o_add_b,
  output logic                   o_add_cin,
  input  logic [WORD_W-1:0]      i_add_s,
  input  logic                   i_add_cout,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [IDW-1:0]         o_rsp_id,
  output logic [WORD_W-1:0]      o_rsp_sum,
  output logic [WIW-1:0]         o_rsp_widx,
  output logic                   o_rsp_last,
  output logic                   o_rsp_cout,
  output logic                   o_rsp_err
);

  cla_seq_state_t    r_state;
  logic [IDW-1:0]    r_owner;
  logic [IDW-1:0]    r_ptr;
  logic [WIW-1:0]    r_widx;
  logic              r_first;
  logic              r_carry;
  logic              r_rsp_valid;
  logic [IDW-1:0]    r_rsp_id;
  logic [WORD_W-1:0] r_rsp_sum;
  logic [WIW-1:0]    r_rsp_widx;
  logic              r_rsp_last;
  logic              r_rsp_cout;
  logic              r_rsp_err;

  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_pick;
  logic              w_busy;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_terminal;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_pick = IDW'(i);
    end
  end

  assign w_busy      = (r_state == ST_BUSY);
  assign w_slot_free = ~r_rsp_valid | i_rsp_ready;
  assign w_accept    = w_busy & i_req_valid[r_owner] & w_slot_free;
  assign w_terminal  = i_req_last[r_owner] | (r_widx == WIW'(MAXW - 1));

  // The adder is always fed from the current owner; its result only matters on acceptance.
  assign o_add_a   = i_req_a[r_owner*WORD_W +: WORD_W];
  assign o_add_b   = i_req_b[r_owner*WORD_W +: WORD_W];
  assign o_add_cin = r_first ? i_req_cin[r_owner] : r_carry;

  always_comb begin
    o_req_ready = '0;
    if (w_busy && w_slot_free) o_req_ready[r_owner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_widx      <= '0;
      r_first     <= 1'b0;
      r_carry     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_widx  <= '0;
      r_rsp_last  <= 1'b0;
      r_rsp_cout  <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|i_req_valid) begin
            r_owner <= w_pick;
            r_widx  <= '0;
            r_first <= 1'b1;
            r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_accept) begin
            r_carry <= i_add_cout;
            r_first <= 1'b0;
            r_widx  <= r_widx + 1'b1;
            if (w_terminal) begin
              r_ptr   <= (r_owner == IDW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_id    <= r_owner;
        r_rsp_sum   <= i_add_s;
        r_rsp_widx  <= r_widx;
        r_rsp_last  <= w_terminal;
        r_rsp_cout  <= w_terminal & i_add_cout;
        r_rsp_err   <= w_terminal & ~i_req_last[r_owner];
      end else if (i_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_widx  = r_rsp_widx;
  assign o_rsp_last  = r_rsp_last;
  assign o_rsp_cout  = r_rsp_cout;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_cla16_seq_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cla16_seq_arbiter
// Brief   : Bench-side adder, operation-level reference model and scoreboard.
// Revision: 1.0
// ============================================================================
module tb_cla16_seq_arbiter;

  localparam int NREQ = 4;
  localparam int MAXW = 8;
  localparam int IDW  = 2;
  localparam int WIW  = 3;
  localparam int SW   = MAXW*16 + 16;

  typedef struct packed {
    logic [MAXW*16-1:0] a;
    logic [MAXW*16-1:0] b;
    logic [4:0]         n;
    logic               has_last;
    logic               cin;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [15:0]    sum;
    logic [WIW-1:0] widx;
    logic           last;
    logic           cout;
    logic           err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0]    req_valid, req_cin, req_last, req_ready;
  logic [NREQ*16-1:0] req_a, req_b;
  logic [15:0]        add_a, add_b, add_s;
  logic               add_cin, add_cout;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic [WIW-1:0]     rsp_widx;
  logic               rsp_last, rsp_cout, rsp_err;

  always #5 clk = ~clk;

  // Stand-in for the shared CLA_16b: purely combinational.
  assign {add_cout, add_s} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  cla16_seq_arbiter #(.NREQ(NREQ), .MAXW(MAXW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_cin   (req_cin),
    .i_req_last  (req_last),
    .o_req_ready (req_ready),
    .o_add_a     (add_a),
    .o_add_b     (add_b),
    .o_add_cin   (add_cin),
    .i_add_s     (add_s),
    .i_add_cout  (add_cout),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_widx  (rsp_widx),
    .o_rsp_last  (rsp_last),
    .o_rsp_cout  (rsp_cout),
    .o_rsp_err   (rsp_err)
  );

  op_t  opq[NREQ][$];
  int   di[NREQ];
  logic [NREQ-1:0] acc;
  rsp_t expq[$];
  rsp_t logq[$];
  int   logc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   rmode = 0;
  bit   drop = 1'b0;
  bit   m_busy = 1'b0;
  bit   m_rv = 1'b0;
  int   m_owner = 0;
  int   m_ptr = 0;
  int   m_cnt = 0;
  int   m_n = 0;
  int   first_seen = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom % 4)
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic op_t mk_op(input int n, input bit has_last);
    op_t o = '0;
    o.n        = 5'(n);
    o.has_last = has_last;
    o.cin      = 1'($urandom % 2);
    for (int w = 0; w < n; w++) begin
      o.a[16*w +: 16] = rnd16();
      o.b[16*w +: 16] = rnd16();
    end
    return o;
  endfunction

  function automatic op_t lit_op(input int n, input logic [31:0] a, input logic [31:0] b, input logic cin);
    op_t o = '0;
    o.n        = 5'(n);
    o.has_last = 1'b1;
    o.cin      = cin;
    o.a[31:0]  = a;
    o.b[31:0]  = b;
    return o;
  endfunction

  // Whole operation as one wide addition; each response word is a 16-bit slice of it.
  task automatic push_exp(input int id, input op_t o);
    logic [SW-1:0] s;
    rsp_t r;
    s = SW'(o.a) + SW'(o.b) + SW'(o.cin);
    for (int w = 0; w < int'(o.n); w++) begin
      r.id   = IDW'(id);
      r.sum  = s[16*w +: 16];
      r.widx = WIW'(w);
      r.last = (w == int'(o.n) - 1);
      r.cout = r.last ? s[16*int'(o.n)] : 1'b0;
      r.err  = r.last & ~o.has_last;
      expq.push_back(r);
    end
  endtask

  task automatic drive();
    op_t o;
    for (int i = 0; i < NREQ; i++) begin
      req_a[16*i +: 16] = 16'($urandom);
      req_b[16*i +: 16] = 16'($urandom);
      req_cin[i]   = 1'($urandom % 2);
      req_last[i]  = 1'($urandom % 2);
      req_valid[i] = 1'b0;
      if (opq[i].size() > 0 && !(drop && ($urandom % 5 == 0))) begin
        o = opq[i][0];
        req_valid[i]      = 1'b1;
        req_a[16*i +: 16] = o.a[16*di[i] +: 16];
        req_b[16*i +: 16] = o.b[16*di[i] +: 16];
        req_last[i]       = o.has_last && (di[i] == int'(o.n) - 1);
        if (di[i] == 0) req_cin[i] = o.cin;
      end
    end
    rsp_ready = (rmode == 0) ? 1'b1 : (rmode == 2) ? 1'b0 : ($urandom % 4 != 0);
  endtask

  task automatic advance();
    op_t o;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        di[i]++;
        if (di[i] == int'(opq[i][0].n)) begin
          o = opq[i].pop_front();
          di[i] = 0;
        end
      end
    end
  endtask

  task automatic monitor();
    logic [NREQ-1:0] exp_rdy;
    rsp_t a, e;
    bit   found;
    int   j;
    acc = '0;
    if (rst) begin
      chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_widx, rsp_last, rsp_cout, rsp_err}), 64'd0);
      m_busy = 1'b0; m_rv = 1'b0; m_ptr = 0;
      expq.delete();
      return;
    end
    exp_rdy = '0;
    if (m_busy && (!m_rv || rsp_ready)) exp_rdy[m_owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
    if (rsp_valid && rsp_ready) begin
      a = {rsp_id, rsp_sum, rsp_widx, rsp_last, rsp_cout, rsp_err};
      logq.push_back(a);
      logc.push_back(cyc);
      if (expq.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rsp_unexpected: got 0x%0h, expected no response (cycle %0d)", a, cyc);
      end else begin
        e = expq.pop_front();
        chk("rsp_word", 64'(a), 64'(e));
      end
    end
    if (rsp_valid && first_seen < 0) first_seen = cyc;
    acc = req_valid & req_ready;
    // Advance the reference to what the upcoming clock edge must do.
    if (m_busy) begin
      if (req_valid[m_owner] && (!m_rv || rsp_ready)) begin
        m_rv = 1'b1;
        m_cnt++;
        if (m_cnt == m_n) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % NREQ;
        end
      end else if (rsp_ready) begin
        m_rv = 1'b0;
      end
    end else begin
      if (rsp_ready) m_rv = 1'b0;
      if (req_valid != '0) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (!found && req_valid[j]) begin
            found = 1'b1;
            m_owner = j;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 0;
        m_n    = int'(opq[m_owner][0].n);
        push_exp(m_owner, opq[m_owner][0]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    advance();
    drive();
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      opq[i].delete();
      di[i] = 0;
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    repeat (3) step();
    rst = 1'b0;
  endtask

  function automatic bit pending();
    bit p = m_busy || (expq.size() != 0) || rsp_valid;
    for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input int budget);
    int t = 0;
    while (pending() && t < budget) begin
      step();
      t++;
    end
    if (t >= budget) begin
      n_chk++; n_err++;
      $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   t0;
    int   rr_exp[5];
    logic [15:0] s0;
    rr_exp = '{0, 1, 2, 3, 0};
    req_valid = '0; req_cin = '0; req_last = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) di[i] = 0;
    do_reset();

    // Single word: 0xFFFF + 0x0001 wraps to zero with carry out.
    logq.delete(); first_seen = -1; t0 = cyc;
    opq[0].push_back(lit_op(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0));
    drain(40);
    chk("t1_count", 64'(logq.size()), 64'd1);
    chk("t1_resp", 64'(logq[0]), 64'({2'd0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0}));
    chk("t1_latency", 64'(first_seen - (t0 + 1)), 64'd2);

    // Two-word carry chain with operation carry-in.
    logq.delete();
    opq[2].push_back(lit_op(2, 32'h0000_FFFF, 32'h0000_0001, 1'b1));
    drain(40);
    chk("t2_word0", 64'(logq[0]), 64'({2'd2, 16'h0001, 3'd0, 1'b0, 1'b0, 1'b0}));
    chk("t2_word1", 64'(logq[1]), 64'({2'd2, 16'h0001, 3'd1, 1'b1, 1'b0, 1'b0}));

    // Round-robin from reset with one bubble between operations.
    do_reset();
    logq.delete(); logc.delete();
    opq[0].push_back(mk_op(1, 1'b1));
    opq[0].push_back(mk_op(1, 1'b1));
    for (int i = 1; i < NREQ; i++) opq[i].push_back(mk_op(1, 1'b1));
    drain(100);
    chk("rr_count", 64'(logq.size()), 64'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(logq[k].id), 64'(rr_exp[k]));
    for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(logc[k+1] - logc[k]), 64'd2);

    // Backpressure on a three-word operation.
    logq.delete();
    rmode = 2;
    opq[1].push_back(mk_op(3, 1'b1));
    repeat (3) step();
    s0 = rsp_sum;
    chk("bp_valid_held", 64'(rsp_valid), 64'd1);
    repeat (5) begin
      step();
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_sum_stable", 64'(rsp_sum), 64'(s0));
    end
    rmode = 0;
    drain(60);
    chk("bp_count", 64'(logq.size()), 64'd3);

    // Truncation at MAXW words without a last flag.
    logq.delete();
    opq[3].push_back(mk_op(MAXW, 1'b0));
    drain(60);
    chk("tr_count", 64'(logq.size()), 64'(MAXW));
    chk("tr_final", 64'({logq[MAXW-1].widx, logq[MAXW-1].last, logq[MAXW-1].err}), 64'({3'd7, 1'b1, 1'b1}));
    logq.delete();
    opq[1].push_back(mk_op(1, 1'b1));
    opq[0].push_back(mk_op(1, 1'b1));
    drain(60);
    chk("tr_next_grant", 64'({logq[0].id, logq[1].id}), 64'({2'd0, 2'd1}));

    // Asynchronous reset in the middle of a four-word operation.
    logq.delete();
    opq[1].push_back(mk_op(4, 1'b1));
    for (int t = 0; t < 30 && di[1] != 2; t++) step();
    chk("rst_reached_word2", 64'(di[1]), 64'd2);
    #2 rst = 1'b1;
    #1 chk("rst_async", 64'({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_widx, rsp_last, rsp_cout, rsp_err}), 64'd0);
    flush();
    repeat (2) step();
    rst = 1'b0;
    logq.delete();
    opq[0].push_back(lit_op(1, 32'h0000_0001, 32'h0000_0001, 1'b1));
    drain(40);
    chk("rst_post_op", 64'(logq[0]), 64'({2'd0, 16'h0003, 3'd0, 1'b1, 1'b0, 1'b0}));

    // Randomized mix: dropouts, random backpressure, truncations.
    rmode = 1; drop = 1'b1;
    repeat (800) begin
      if ($urandom % 3 == 0) begin
        int i;
        i = int'($urandom % NREQ);
        if (opq[i].size() < 3) begin
          if ($urandom % 6 == 0) opq[i].push_back(mk_op(MAXW, 1'b0));
          else                   opq[i].push_back(mk_op(int'($urandom_range(1, MAXW)), 1'b1));
        end
      end
      step();
    end
    drop = 1'b0; rmode = 0;
    drain(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
